// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, deframes
// scan-code bytes and translates a small make/break set into a held HID usage code.
`timescale 1ns/1ps

module ps2_keycode #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_event,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Input synchronizers, idle-high like the bus itself.
   logic clk_meta_q, clk_meta_d;
   logic clk_sync_q, clk_sync_d;
   logic data_meta_q, data_meta_d;
   logic data_sync_q, data_sync_d;

   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall_edge;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_valid;
   logic          frame_bad;

   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic [7:0]    keycode_q, keycode_d;
   logic          key_event_q, key_event_d;
   logic          frame_err_q, frame_err_d;
   logic [8:0]    lookup;

   // Returns {hit, usage}; hit=0 means the pair is not in the table.
   function automatic logic [8:0] map_code(input logic ext, input logic [7:0] code);
      logic [8:0] res;
      res = 9'h000;
      if (!ext) begin
         case (code)
            8'h1C:   res = 9'h104;
            8'h23:   res = 9'h107;
            8'h29:   res = 9'h12C;
            8'h5A:   res = 9'h128;
            default: res = 9'h000;
         endcase
      end else begin
         case (code)
            8'h6B:   res = 9'h150;
            8'h74:   res = 9'h14F;
            8'h75:   res = 9'h152;
            8'h72:   res = 9'h151;
            default: res = 9'h000;
         endcase
      end
      return res;
   endfunction

   always_comb begin
      clk_meta_d  = ps2_clk;
      clk_sync_d  = clk_meta_q;
      data_meta_d = ps2_data;
      data_sync_d = data_meta_q;
   end

   // The filtered clock only follows the line after FILTER_LEN agreeing samples.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = filt_cnt_q;
      if (clk_sync_q == filt_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
         filt_d     = clk_sync_q;
         filt_cnt_d = '0;
      end else begin
         filt_cnt_d = filt_cnt_q + FW'(1);
      end
      fall_edge = filt_q & ~filt_d;
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      tmo_d      = tmo_q;
      byte_valid = 1'b0;
      frame_bad  = 1'b0;

      // An edge always wins over timeout, so the two error sources never coincide.
      if (state_q == IDLE || fall_edge) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         tmo_d     = '0;
         frame_bad = 1'b1;
         state_d   = IDLE;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      if (fall_edge) begin
         case (state_q)
            IDLE: begin
               if (!data_sync_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d   = {data_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               parity_d = data_sync_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if ((^{shift_q, parity_q}) && data_sync_q) begin
                  byte_valid = 1'b1;
               end else begin
                  frame_bad = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      keycode_d   = keycode_q;
      frame_err_d = 1'b0;
      lookup      = map_code(ext_q, shift_q);

      if (frame_bad) begin
         frame_err_d = 1'b1;
         ext_d       = 1'b0;
         brk_d       = 1'b0;
      end else if (byte_valid) begin
         if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            if (lookup[8]) begin
               if (!brk_q) begin
                  keycode_d = lookup[7:0];
               end else if (keycode_q == lookup[7:0]) begin
                  keycode_d = 8'h00;
               end
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
      // Typematic repeats leave keycode unchanged and therefore stay silent.
      key_event_d = (keycode_d != keycode_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         keycode_q   <= 8'h00;
         key_event_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_meta_q  <= clk_meta_d;
         clk_sync_q  <= clk_sync_d;
         data_meta_q <= data_meta_d;
         data_sync_q <= data_sync_d;
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         keycode_q   <= keycode_d;
         key_event_q <= key_event_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign keycode   = keycode_q;
   assign key_event = key_event_q;
   assign frame_err = frame_err_q;

endmodule
